// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and timing constants for the Morse encoder
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ELEM,
    GAP,
    CSPACE,
    CHOLD,
    WSPACE,
    WHOLD,
    ERR
  } morse_state_e;

  // Pattern is left-aligned: bit 4 is the first element sent, 1 = dash.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_code_t;

  localparam int         CHAR_HOLD   = 3;
  localparam int         WORD_HOLD   = 7;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic morse_code_t mc(input logic [2:0] len, input logic [4:0] pattern);
    morse_code_t c;
    c.len     = len;
    c.pattern = pattern;
    return c;
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// rtl/morse_encoder_if.sv - character input handshake and symbol pulse outputs
interface morse_encoder_if;
  logic [7:0] ascii_in;
  logic       valid_in;
  logic       ready_out;
  logic       dot_out;
  logic       dash_out;
  logic       char_space_out;
  logic       word_space_out;
  logic       err_out;

  modport master (
    output ascii_in, valid_in,
    input  ready_out, dot_out, dash_out, char_space_out, word_space_out, err_out
  );

  modport slave (
    input  ascii_in, valid_in,
    output ready_out, dot_out, dash_out, char_space_out, word_space_out, err_out
  );
endinterface

// File: rtl/morse_code_rom.sv
// rtl/morse_code_rom.sv - combinational ASCII to ITU Morse code lookup
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic [2:0] len_o,
  output logic [4:0] pattern_o,
  output logic       supported_o
);

  logic [7:0]  upper;
  morse_code_t code;

  always_comb begin
    upper = ascii_i;
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) upper = ascii_i - 8'h20;
    code        = '0;
    supported_o = 1'b1;
    case (upper)
      8'h41: code = mc(3'd2, 5'b01000);
      8'h42: code = mc(3'd4, 5'b10000);
      8'h43: code = mc(3'd4, 5'b10100);
      8'h44: code = mc(3'd3, 5'b10000);
      8'h45: code = mc(3'd1, 5'b00000);
      8'h46: code = mc(3'd4, 5'b00100);
      8'h47: code = mc(3'd3, 5'b11000);
      8'h48: code = mc(3'd4, 5'b00000);
      8'h49: code = mc(3'd2, 5'b00000);
      8'h4A: code = mc(3'd4, 5'b01110);
      8'h4B: code = mc(3'd3, 5'b10100);
      8'h4C: code = mc(3'd4, 5'b01000);
      8'h4D: code = mc(3'd2, 5'b11000);
      8'h4E: code = mc(3'd2, 5'b10000);
      8'h4F: code = mc(3'd3, 5'b11100);
      8'h50: code = mc(3'd4, 5'b01100);
      8'h51: code = mc(3'd4, 5'b11010);
      8'h52: code = mc(3'd3, 5'b01000);
      8'h53: code = mc(3'd3, 5'b00000);
      8'h54: code = mc(3'd1, 5'b10000);
      8'h55: code = mc(3'd3, 5'b00100);
      8'h56: code = mc(3'd4, 5'b00010);
      8'h57: code = mc(3'd3, 5'b01100);
      8'h58: code = mc(3'd4, 5'b10010);
      8'h59: code = mc(3'd4, 5'b10110);
      8'h5A: code = mc(3'd4, 5'b11000);
      8'h30: code = mc(3'd5, 5'b11111);
      8'h31: code = mc(3'd5, 5'b01111);
      8'h32: code = mc(3'd5, 5'b00111);
      8'h33: code = mc(3'd5, 5'b00011);
      8'h34: code = mc(3'd5, 5'b00001);
      8'h35: code = mc(3'd5, 5'b00000);
      8'h36: code = mc(3'd5, 5'b10000);
      8'h37: code = mc(3'd5, 5'b11000);
      8'h38: code = mc(3'd5, 5'b11100);
      8'h39: code = mc(3'd5, 5'b11110);
      // Space is supported but carries no elements; the FSM handles it.
      ASCII_SPACE: code = '0;
      default: supported_o = 1'b0;
    endcase
  end

  assign len_o     = code.len;
  assign pattern_o = code.pattern;

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - accepts one ASCII character and emits Morse element/gap pulses
module morse_encoder
  import morse_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  morse_encoder_if.slave  bus
);

  morse_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [4:0]   sh_q, sh_d;
  logic         ready_q, dot_q, dash_q, cs_q, ws_q, err_q;
  logic         ready_d, dot_d, dash_d, cs_d, ws_d, err_d;
  logic [2:0]   rom_len;
  logic [4:0]   rom_pat;
  logic         rom_ok;
  logic         accept;

  morse_code_rom u_rom (
    .ascii_i     (bus.ascii_in),
    .len_o       (rom_len),
    .pattern_o   (rom_pat),
    .supported_o (rom_ok)
  );

  assign accept = bus.valid_in && ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ready_q <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      cs_q    <= 1'b0;
      ws_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ready_q <= ready_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      cs_q    <= cs_d;
      ws_q    <= ws_d;
      err_q   <= err_d;
    end
  end

  // cnt_q holds elements still to send after the current one, or hold cycles left.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.ascii_in == ASCII_SPACE) begin
            state_d = WSPACE;
          end else if (rom_ok) begin
            state_d = ELEM;
            cnt_d   = rom_len - 3'd1;
            sh_d    = rom_pat;
          end else begin
            state_d = ERR;
          end
        end
      end
      ELEM: begin
        if (cnt_q == 3'd0) begin
          state_d = CSPACE;
        end else begin
          state_d = GAP;
          cnt_d   = cnt_q - 3'd1;
          sh_d    = {sh_q[3:0], 1'b0};
        end
      end
      GAP:    state_d = ELEM;
      CSPACE: begin
        state_d = CHOLD;
        cnt_d   = 3'(CHAR_HOLD - 1);
        sh_d    = '0;
      end
      WSPACE: begin
        state_d = WHOLD;
        cnt_d   = 3'(WORD_HOLD - 1);
      end
      CHOLD, WHOLD: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pulse lines up with it.
  always_comb begin
    ready_d = (state_d == IDLE);
    dot_d   = (state_d == ELEM) && !sh_d[4];
    dash_d  = (state_d == ELEM) &&  sh_d[4];
    cs_d    = (state_d == CSPACE);
    ws_d    = (state_d == WSPACE);
    err_d   = (state_d == ERR);
  end

  assign bus.ready_out      = ready_q;
  assign bus.dot_out        = dot_q;
  assign bus.dash_out       = dash_q;
  assign bus.char_space_out = cs_q;
  assign bus.word_space_out = ws_q;
  assign bus.err_out        = err_q;

endmodule
